// File: rtl/pipelined_shifter.sv
// Purpose : parametrised barrel shifter (SLL/SRL/SRA/ROL); each pipeline stage applies one shift of 2^k.
// Latency : LATENCY (= SHAMT_W) cycles from input transfer to valid_o; one result per cycle when unstalled.
// Backpr. : the whole pipe freezes while valid_o=1 and ready_i=0; ready_o drops and no input is captured.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o      operand handshake; data_i operand, shamt_i amount, op_i 00 SLL 01 SRL 10 SRA 11 ROL
//   valid_o/ready_i      result handshake; data_o result, carry_o last bit shifted out (0 when shamt=0)
module pipelined_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int LATENCY = SHAMT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               carry_o
);

    if (LATENCY != SHAMT_W) begin : g_bad_latency
        $error("pipelined_shifter: LATENCY must equal SHAMT_W");
    end
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
        $error("pipelined_shifter: SHAMT_W must equal $clog2(WIDTH)");
    end
    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_shifter: WIDTH must be a power of two in 8..64");
    end

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    // One pipeline slot. The full shamt travels along; stage k only looks at bit k.
    typedef struct packed {
        logic               vld;
        op_e                op;
        logic [SHAMT_W-1:0] shamt;
        logic               carry;
        logic [WIDTH-1:0]   dat;
    } stage_t;

    stage_t stage_q [LATENCY];
    stage_t stage_d [LATENCY];
    stage_t in_s;
    logic   advance;

    // Conditionally shift a slot by 2^k. Because layers run in ascending order,
    // the last layer that actually shifts determines the carry; a layer that
    // does not shift leaves data and carry untouched. For ROL the carry tracks
    // the current LSB, which a non-shifting layer also leaves unchanged.
    function automatic stage_t shift_stage(input stage_t s, input int k);
        stage_t             r;
        int                 amt;
        logic [SHAMT_W-1:0] sh_bits;
        logic [WIDTH-1:0]   tmp;
        r       = s;
        amt     = 1 << k;
        sh_bits = s.shamt >> k;
        if (sh_bits[0]) begin
            case (s.op)
                OP_SLL: begin
                    r.dat   = s.dat << amt;
                    tmp     = s.dat >> (WIDTH - amt);
                    r.carry = tmp[0];
                end
                OP_SRL: begin
                    r.dat   = s.dat >> amt;
                    tmp     = s.dat >> (amt - 1);
                    r.carry = tmp[0];
                end
                OP_SRA: begin
                    r.dat   = $signed(s.dat) >>> amt;
                    tmp     = s.dat >> (amt - 1);
                    r.carry = tmp[0];
                end
                OP_ROL: begin
                    r.dat   = (s.dat << amt) | (s.dat >> (WIDTH - amt));
                    r.carry = r.dat[0];
                end
            endcase
        end
        return r;
    endfunction

    assign valid_o = stage_q[LATENCY-1].vld;
    assign data_o  = stage_q[LATENCY-1].dat;
    assign carry_o = stage_q[LATENCY-1].carry;
    assign advance = ready_i | ~valid_o;
    assign ready_o = advance;

    always_comb begin
        // Bubbles enter as an all-zero slot, so whatever sits on the operand
        // inputs while valid_i=0 can never reach the valid or carry outputs.
        in_s = '0;
        if (valid_i) begin
            in_s.vld   = 1'b1;
            in_s.op    = op_e'(op_i);
            in_s.shamt = shamt_i;
            in_s.dat   = data_i;
        end
        stage_d[0] = shift_stage(in_s, 0);
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k] = shift_stage(stage_q[k-1], k);
        end
    end

    // All stages load together on advance, so a stall freezes every slot in place.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Purpose : bench for pipelined_shifter at WIDTH=32 and WIDTH=8 against a direct arithmetic model.
// Latency : expects 5 cycles (WIDTH=32) and 3 cycles (WIDTH=8) from acceptance to valid_o.
// Backpr. : drives random and directed ready_i stalls plus input bubbles.
module tb_pipelined_shifter;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_n;

    logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_carry_o;
    logic [31:0] a_data_i, a_data_o;
    logic [4:0]  a_shamt_i;
    logic [1:0]  a_op_i;

    logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_carry_o;
    logic [7:0]  b_data_i, b_data_o;
    logic [2:0]  b_shamt_i;
    logic [1:0]  b_op_i;

    pipelined_shifter #(.WIDTH(32)) u_a (
        .clk_i(clk_i), .rst_i(rst_n),
        .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i), .shamt_i(a_shamt_i), .op_i(a_op_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .carry_o(a_carry_o)
    );

    pipelined_shifter #(.WIDTH(8)) u_b (
        .clk_i(clk_i), .rst_i(rst_n),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i), .shamt_i(b_shamt_i), .op_i(b_op_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .carry_o(b_carry_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [64:0] res;   // {carry, data}
        int          acc;   // cycle count at acceptance
    } exp_t;

    exp_t        a_exp_q[$], b_exp_q[$];
    logic [64:0] a_obs_q[$], b_obs_q[$];
    bit a_chk_lat = 0, b_chk_lat = 0, a_rand_rdy = 0, b_rand_rdy = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Direct model: whole shift in one step on a masked 64-bit value.
    function automatic logic [64:0] ref_op(input int w, input logic [63:0] d_in, input int s,
                                           input logic [1:0] op);
        logic [63:0] mask, d, r, tmp;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        d    = d_in & mask;
        r    = '0;
        c    = 1'b0;
        case (op)
            2'd0: begin
                r = (d << s) & mask;
                if (s != 0) begin tmp = d >> (w - s); c = tmp[0]; end
            end
            2'd1: begin
                r = d >> s;
                if (s != 0) begin tmp = d >> (s - 1); c = tmp[0]; end
            end
            2'd2: begin
                r = d >> s;
                tmp = d >> (w - 1);
                if (tmp[0]) r = r | (mask & ~(mask >> s));
                if (s != 0) begin tmp = d >> (s - 1); c = tmp[0]; end
            end
            default: begin
                r = ((d << s) | (d >> (w - s))) & mask;
                if (s != 0) c = r[0];
            end
        endcase
        return {c, r};
    endfunction

    // Scoreboards: sampled on the falling edge, when handshakes are stable.
    always @(negedge clk_i) begin : sb_a
        exp_t e;
        exp_t n;
        if (rst_n) begin
            if (a_valid_o && a_ready_i) begin
                if (a_exp_q.size() == 0) begin
                    chk("a_spurious", 64'(a_valid_o), 64'd0);
                end else begin
                    e = a_exp_q.pop_front();
                    chk("a_data", 64'(a_data_o), e.res[63:0]);
                    chk("a_carry", 64'(a_carry_o), 64'(e.res[64]));
                    if (a_chk_lat) chk("a_latency", 64'(cyc - e.acc), 64'd5);
                    a_obs_q.push_back({a_carry_o, 32'd0, a_data_o});
                end
            end
            if (a_valid_i && a_ready_o) begin
                n.res = ref_op(32, 64'(a_data_i), int'(a_shamt_i), a_op_i);
                n.acc = cyc;
                a_exp_q.push_back(n);
            end
        end
    end

    always @(negedge clk_i) begin : sb_b
        exp_t e;
        exp_t n;
        if (rst_n) begin
            if (b_valid_o && b_ready_i) begin
                if (b_exp_q.size() == 0) begin
                    chk("b_spurious", 64'(b_valid_o), 64'd0);
                end else begin
                    e = b_exp_q.pop_front();
                    chk("b_data", 64'(b_data_o), e.res[63:0]);
                    chk("b_carry", 64'(b_carry_o), 64'(e.res[64]));
                    if (b_chk_lat) chk("b_latency", 64'(cyc - e.acc), 64'd3);
                    b_obs_q.push_back({b_carry_o, 56'd0, b_data_o});
                end
            end
            if (b_valid_i && b_ready_o) begin
                n.res = ref_op(8, 64'(b_data_i), int'(b_shamt_i), b_op_i);
                n.acc = cyc;
                b_exp_q.push_back(n);
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (a_rand_rdy) a_ready_i = ($urandom_range(3) != 0);
        if (b_rand_rdy) b_ready_i = ($urandom_range(3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic a_send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        int t = 0;
        a_valid_i = 1'b1; a_data_i = d; a_shamt_i = s; a_op_i = op;
        @(negedge clk_i);
        while (!a_ready_o && t < 1000) begin @(negedge clk_i); t++; end
        if (!a_ready_o) chk("a_send_timeout", 64'(a_ready_o), 64'd1);
        @(posedge clk_i); #1;
        a_valid_i = 1'b0; a_data_i = $urandom; a_shamt_i = 5'($urandom); a_op_i = 2'($urandom);
    endtask

    task automatic b_send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
        int t = 0;
        b_valid_i = 1'b1; b_data_i = d; b_shamt_i = s; b_op_i = op;
        @(negedge clk_i);
        while (!b_ready_o && t < 1000) begin @(negedge clk_i); t++; end
        if (!b_ready_o) chk("b_send_timeout", 64'(b_ready_o), 64'd1);
        @(posedge clk_i); #1;
        b_valid_i = 1'b0; b_data_i = 8'($urandom); b_shamt_i = 3'($urandom); b_op_i = 2'($urandom);
    endtask

    task automatic a_drain();
        int t = 0;
        while (a_exp_q.size() != 0 && t < 1000) begin @(negedge clk_i); t++; end
        chk("a_drain", 64'(a_exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic b_drain();
        int t = 0;
        while (b_exp_q.size() != 0 && t < 1000) begin @(negedge clk_i); t++; end
        chk("b_drain", 64'(b_exp_q.size()), 64'd0);
        idle(2);
    endtask

    // Directed ops/boundary table (WIDTH=32).
    logic [31:0] t_d   [8] = '{32'h8000_00F1, 32'h8000_00F1, 32'h8000_00F1, 32'h8000_00F1,
                               32'h0000_0003, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0003};
    logic [4:0]  t_s   [8] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd1, 5'd0, 5'd0, 5'd31};
    logic [1:0]  t_op  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] t_res [8] = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F18,
                               32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000};
    logic        t_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_valid_i = 0; a_ready_i = 1; a_data_i = '0; a_shamt_i = '0; a_op_i = '0;
        b_valid_i = 0; b_ready_i = 1; b_data_i = '0; b_shamt_i = '0; b_op_i = '0;
        #12;
        chk("rst_a_valid", 64'(a_valid_o), 64'd0);
        chk("rst_a_data", 64'(a_data_o), 64'd0);
        chk("rst_a_carry", 64'(a_carry_o), 64'd0);
        chk("rst_a_ready", 64'(a_ready_o), 64'd1);
        chk("rst_b_valid", 64'(b_valid_o), 64'd0);
        chk("rst_b_ready", 64'(b_ready_o), 64'd1);
        #1 rst_n = 1'b1;
        idle(1);

        // Latency and throughput: 5 back-to-back ops, first is SLL 1 by 2.
        a_chk_lat = 1;
        a_obs_q.delete();
        a_send(32'h1, 5'd2, 2'd0);
        for (int i = 0; i < 4; i++) a_send($urandom, 5'($urandom), 2'($urandom));
        a_drain();
        a_chk_lat = 0;
        chk("lat_count", 64'(a_obs_q.size()), 64'd5);
        if (a_obs_q.size() > 0) chk("lat_first", a_obs_q[0][63:0], 64'h4);

        // Ops sweep and boundary cases against fixed values.
        a_obs_q.delete();
        for (int i = 0; i < 8; i++) a_send(t_d[i], t_s[i], t_op[i]);
        a_drain();
        chk("tbl_count", 64'(a_obs_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < a_obs_q.size(); i++) begin
            chk($sformatf("tbl_data%0d", i), a_obs_q[i][63:0], 64'(t_res[i]));
            chk($sformatf("tbl_carry%0d", i), 64'(a_obs_q[i][64]), 64'(t_c[i]));
        end

        // Backpressure: fill the pipe, stall 7 cycles with a new op offered.
        a_obs_q.delete();
        a_ready_i = 0;
        for (int i = 0; i < 5; i++) a_send($urandom, 5'($urandom), 2'($urandom));
        a_valid_i = 1; a_data_i = 32'h1234_5678; a_shamt_i = 5'd8; a_op_i = 2'd3;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            chk("bp_ready", 64'(a_ready_o), 64'd0);
            chk("bp_valid", 64'(a_valid_o), 64'd1);
            if (a_exp_q.size() > 0) begin
                chk("bp_data", 64'(a_data_o), a_exp_q[0].res[63:0]);
                chk("bp_carry", 64'(a_carry_o), 64'(a_exp_q[0].res[64]));
            end
        end
        chk("bp_inflight", 64'(a_exp_q.size()), 64'd5);
        @(posedge clk_i); #1;
        a_ready_i = 1;
        a_send(32'h1234_5678, 5'd8, 2'd3);
        for (int i = 0; i < 3; i++) a_send($urandom, 5'($urandom), 2'($urandom));
        a_drain();
        chk("bp_count", 64'(a_obs_q.size()), 64'd9);

        // Reset mid-stream: 3 ops in flight, first one held at the output.
        a_ready_i = 0;
        a_send(32'hFFFF_FFFF, 5'd0, 2'd0);
        a_send(32'hA5A5_A5A5, 5'd3, 2'd1);
        a_send(32'h0F0F_0F0F, 5'd7, 2'd3);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(a_valid_o), 64'd0);
        chk("mid_rst_data", 64'(a_data_o), 64'd0);
        chk("mid_rst_carry", 64'(a_carry_o), 64'd0);
        chk("mid_rst_ready", 64'(a_ready_o), 64'd1);
        a_exp_q.delete();
        b_exp_q.delete();
        @(posedge clk_i); #2 rst_n = 1'b1;
        a_ready_i = 1;
        idle(10);
        chk("post_rst_valid", 64'(a_valid_o), 64'd0);

        // Randomised WIDTH=32 run with stalls and bubbles.
        a_rand_rdy = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            a_send($urandom, 5'($urandom), 2'($urandom));
        end
        a_rand_rdy = 0;
        a_ready_i = 1;
        a_drain();

        // WIDTH=8: directed SRA plus latency, then a long random run.
        b_chk_lat = 1;
        b_obs_q.delete();
        b_send(8'h90, 3'd3, 2'd2);
        b_drain();
        b_chk_lat = 0;
        chk("b_sra_count", 64'(b_obs_q.size()), 64'd1);
        if (b_obs_q.size() > 0) begin
            chk("b_sra_data", b_obs_q[0][63:0], 64'hF2);
            chk("b_sra_carry", 64'(b_obs_q[0][64]), 64'd0);
        end
        b_rand_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
            b_send(8'($urandom), 3'($urandom), 2'($urandom));
        end
        b_rand_rdy = 0;
        b_ready_i = 1;
        b_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
